hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage MIPS core; sits beside the forwarding logic in ID.
- Detects hazards that forwarding cannot cover: load-use, and branch operands resolved in ID.
- Sequences the multi-cycle MULT/DIV unit and its HI/LO structural hazard.
- Drives PC/IFID write enables, the IDEX bubble, the IFID flush, and a saturating stall-cycle counter.

Parameters:
- MULT_CYCLES, 4: EX-side cycles a MULT/MULTU occupies HI/LO after issue (>=2).
- DIV_CYCLES, 32: cycles a DIV/DIVU occupies HI/LO after issue (>=2).
- CNT_W, 6: width of the busy down-counter; must hold max(MULT_CYCLES, DIV_CYCLES).
- PERF_W, 16: width of the stall-cycle performance counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- IFIDRs  in  5  rs field of the instruction in ID.
- IFIDRt  in  5  rt field of the instruction in ID.
- IFIDUsesRt  in  1  ID instruction reads rt as a source.
- IDBranch  in  1  ID instruction is beq/bne (compared in ID).
- BranchTaken  in  1  ID branch comparison result.
- IDMulDiv  in  1  ID instruction is MULT/MULTU/DIV/DIVU.
- IDIsDiv  in  1  qualifies IDMulDiv: 1 = divide.
- IDReadsHiLo  in  1  ID instruction is MFHI/MFLO.
- IDEXMemRead  in  1  EX instruction is a load.
- IDEXRegWrite  in  1  EX instruction writes a register.
- IDEXRd  in  5  destination register of the EX instruction (rt for loads, already muxed).
- EXMEMMemRead  in  1  MEM instruction is a load.
- EXMEMRd  in  5  destination register of the MEM instruction.
- PCWrite  out  1  PC update enable.
- IFIDWrite  out  1  IF/ID register write enable.
- IDEXBubble  out  1  zero the control fields entering ID/EX.
- IFIDFlush  out  1  squash the instruction entering IF/ID.
- MulDivStart  out  1  one-cycle issue pulse to the MULT/DIV unit.
- MulDivBusy  out  1  HI/LO unit occupied.
- StallCycles  out  PERF_W  saturating count of stalled cycles.

Behaviour:
- Match terms:
  - MatchEXs = IDEXRd!=0 && IDEXRd==IFIDRs.
  - MatchEXt = IDEXRd!=0 && IFIDUsesRt && IDEXRd==IFIDRt.
  - MatchMEMs and MatchMEMt are the same tests against EXMEMRd.
- Stall sources:
  - LoadUse = IDEXMemRead && (MatchEXs || MatchEXt).
  - BrEX = IDBranch && IDEXRegWrite && (MatchEXs || MatchEXt).
  - BrMEM = IDBranch && EXMEMMemRead && (MatchMEMs || MatchMEMt).
  - MDHaz = (IDMulDiv || IDReadsHiLo) && MulDivBusy.
  - Stall = OR of the four sources. Combinational, same cycle as the inputs.
- When Stall=1: PCWrite=0, IFIDWrite=0, IDEXBubble=1.
- When Stall=0: PCWrite=1, IFIDWrite=1, IDEXBubble=0.
- IFIDFlush = IDBranch && BranchTaken && !Stall. A stalled branch never flushes.
- MulDivStart = IDMulDiv && !Stall && state==IDLE.
- FSM states: IDLE and BUSY. Down-counter Cnt is CNT_W wide.
  - IDLE -> BUSY when MulDivStart=1. Cnt loads DIV_CYCLES if IDIsDiv, else MULT_CYCLES.
  - In BUSY, Cnt decrements each cycle. When Cnt==1 the state returns to IDLE on the next edge, with Cnt=0.
  - Result: MulDivBusy=1 for exactly N cycles, starting the cycle after the start pulse.
- MulDivBusy = (state==BUSY), a registered output.
  - An MFHI/MFLO or a new MULT/DIV in ID stalls for every BUSY cycle, including the Cnt==1 cycle.
  - It proceeds on the first IDLE cycle.
- A taken-branch flush, or a load-use stall occurring while BUSY, does not cancel or extend the counter.
- StallCycles increments by 1 on every edge where Stall=1 and rst_n=1, and saturates at all-ones.
- Reset (rst_n=0 at an edge) forces state=IDLE, Cnt=0, StallCycles=0, including mid-BUSY.
  - During and immediately after reset, MulDivBusy=0.
  - The combinational outputs follow the input equations; with all inputs 0 they are PCWrite=1, IFIDWrite=1, IDEXBubble=0, IFIDFlush=0, MulDivStart=0.
- Register $0 never causes a stall.
- Simultaneous sources OR together and count as one stall cycle.

Test Plan:
- Load-use: IDEXMemRead=1, IDEXRd=8, IFIDRs=8 -> PCWrite=0, IFIDWrite=0, IDEXBubble=1 for 1 cycle; StallCycles 0->1. Same with IDEXRd=0 -> no stall.
- Branch after ALU then after load:
  - IDBranch=1, IDEXRegWrite=1, IDEXRd=9, IFIDRt=9, IFIDUsesRt=1 -> stall.
  - Next cycle the writer is in MEM as a load (EXMEMMemRead=1, EXMEMRd=9) -> second stall cycle.
  - Third cycle, BranchTaken=1 -> IFIDFlush=1 only then.
- MULT issue: IDMulDiv=1, IDIsDiv=0 -> MulDivStart pulse 1 cycle; MulDivBusy high exactly 4 cycles. An MFLO held in ID stalls 4 cycles and proceeds on cycle 5.
- DIV back-to-back: DIV issues, then a second DIV is held in ID -> 32 stall cycles; the second MulDivStart fires on the first IDLE cycle; StallCycles=32.
- Reset mid-DIV: rst_n=0 for one edge at Cnt=17 -> MulDivBusy=0 and StallCycles=0 next cycle; a subsequent MFHI proceeds without stall.
- Saturation: PERF_W=4, hold LoadUse for 20 cycles -> StallCycles stops at 15.

Source files
------------

// File: rtl/hazard_stall_ctrl_if.sv
// Signal bundle between the ID-stage pipeline logic and the hazard/stall controller.
// The pipeline side uses the master modport; the controller uses the slave modport.
interface hazard_stall_ctrl_if #(
    parameter int PERF_W = 16
);
    logic [4:0]        IFIDRs;
    logic [4:0]        IFIDRt;
    logic              IFIDUsesRt;
    logic              IDBranch;
    logic              BranchTaken;
    logic              IDMulDiv;
    logic              IDIsDiv;
    logic              IDReadsHiLo;
    logic              IDEXMemRead;
    logic              IDEXRegWrite;
    logic [4:0]        IDEXRd;
    logic              EXMEMMemRead;
    logic [4:0]        EXMEMRd;
    logic              PCWrite;
    logic              IFIDWrite;
    logic              IDEXBubble;
    logic              IFIDFlush;
    logic              MulDivStart;
    logic              MulDivBusy;
    logic [PERF_W-1:0] StallCycles;

    modport master (
        output IFIDRs, IFIDRt, IFIDUsesRt, IDBranch, BranchTaken, IDMulDiv, IDIsDiv,
               IDReadsHiLo, IDEXMemRead, IDEXRegWrite, IDEXRd, EXMEMMemRead, EXMEMRd,
        input  PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, MulDivStart, MulDivBusy, StallCycles
    );

    modport slave (
        input  IFIDRs, IFIDRt, IFIDUsesRt, IDBranch, BranchTaken, IDMulDiv, IDIsDiv,
               IDReadsHiLo, IDEXMemRead, IDEXRegWrite, IDEXRd, EXMEMMemRead, EXMEMRd,
        output PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, MulDivStart, MulDivBusy, StallCycles
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS core: load-use, ID-resolved branch
// operand hazards, and MULT/DIV HI/LO occupancy, plus a saturating stall counter.
module hazard_stall_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6,
    parameter int PERF_W      = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_stall_ctrl_if.slave  bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [PERF_W-1:0] stall_cnt;

    logic match_ex_s;
    logic match_ex_t;
    logic match_mem_s;
    logic match_mem_t;
    logic load_use;
    logic br_ex;
    logic br_mem;
    logic md_haz;
    logic stall;

    // $0 is hardwired to zero, so a producer targeting it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] src,
                                       input logic used);
        return used && (rd != 5'd0) && (rd == src);
    endfunction

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        match_ex_s  = reg_match(bus.IDEXRd,  bus.IFIDRs, 1'b1);
        match_ex_t  = reg_match(bus.IDEXRd,  bus.IFIDRt, bus.IFIDUsesRt);
        match_mem_s = reg_match(bus.EXMEMRd, bus.IFIDRs, 1'b1);
        match_mem_t = reg_match(bus.EXMEMRd, bus.IFIDRt, bus.IFIDUsesRt);
        load_use    = bus.IDEXMemRead && (match_ex_s || match_ex_t);
        br_ex       = bus.IDBranch && bus.IDEXRegWrite && (match_ex_s || match_ex_t);
        br_mem      = bus.IDBranch && bus.EXMEMMemRead && (match_mem_s || match_mem_t);
        md_haz      = (bus.IDMulDiv || bus.IDReadsHiLo) && (state == BUSY);
        stall       = load_use || br_ex || br_mem || md_haz;
    end

    // A stalled branch compares stale operands, so it must not flush.
    assign bus.PCWrite     = !stall;
    assign bus.IFIDWrite   = !stall;
    assign bus.IDEXBubble  = stall;
    assign bus.IFIDFlush   = bus.IDBranch && bus.BranchTaken && !stall;
    assign bus.MulDivStart = bus.IDMulDiv && !stall && (state == IDLE);
    assign bus.MulDivBusy  = (state == BUSY);
    assign bus.StallCycles = stall_cnt;

    // Busy window runs N cycles after issue; flushes and other stalls do not touch it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            stall_cnt <= '0;
        end else begin
            if (stall) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (state == IDLE) begin
                if (bus.MulDivStart) begin
                    state <= BUSY;
                    cnt   <= bus.IDIsDiv ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                end
            end else begin
                if (cnt == CNT_W'(1)) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: load-use, branch hazards, MULT/DIV sequencing,
// reset mid-divide and stall-counter saturation (second instance with a 4-bit counter).
module tb_hazard_stall_ctrl;
    logic clk;
    logic rst_n;
    int   vecs;
    int   errs;

    hazard_stall_ctrl_if #(.PERF_W(16)) bus ();
    hazard_stall_ctrl_if #(.PERF_W(4))  sat_bus ();

    hazard_stall_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6), .PERF_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    hazard_stall_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6), .PERF_W(4)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sat_bus)
    );

    assign sat_bus.IFIDRs       = bus.IFIDRs;
    assign sat_bus.IFIDRt       = bus.IFIDRt;
    assign sat_bus.IFIDUsesRt   = bus.IFIDUsesRt;
    assign sat_bus.IDBranch     = bus.IDBranch;
    assign sat_bus.BranchTaken  = bus.BranchTaken;
    assign sat_bus.IDMulDiv     = bus.IDMulDiv;
    assign sat_bus.IDIsDiv      = bus.IDIsDiv;
    assign sat_bus.IDReadsHiLo  = bus.IDReadsHiLo;
    assign sat_bus.IDEXMemRead  = bus.IDEXMemRead;
    assign sat_bus.IDEXRegWrite = bus.IDEXRegWrite;
    assign sat_bus.IDEXRd       = bus.IDEXRd;
    assign sat_bus.EXMEMMemRead = bus.EXMEMMemRead;
    assign sat_bus.EXMEMRd      = bus.EXMEMRd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // {PCWrite, IFIDWrite, IDEXBubble}: 3'b110 when running, 3'b001 when stalled
    task automatic chk_ctl(input string tag, input bit exp_stall);
        chk(tag, {29'd0, bus.PCWrite, bus.IFIDWrite, bus.IDEXBubble},
            exp_stall ? 32'd1 : 32'd6);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.IFIDRs       = 5'd0;
        bus.IFIDRt       = 5'd0;
        bus.IFIDUsesRt   = 1'b0;
        bus.IDBranch     = 1'b0;
        bus.BranchTaken  = 1'b0;
        bus.IDMulDiv     = 1'b0;
        bus.IDIsDiv      = 1'b0;
        bus.IDReadsHiLo  = 1'b0;
        bus.IDEXMemRead  = 1'b0;
        bus.IDEXRegWrite = 1'b0;
        bus.IDEXRd       = 5'd0;
        bus.EXMEMMemRead = 1'b0;
        bus.EXMEMRd      = 5'd0;
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();

        // Reset state with all inputs low
        chk_ctl("rst_ctl", 1'b0);
        chk("rst_flush", {31'd0, bus.IFIDFlush}, 32'd0);
        chk("rst_start", {31'd0, bus.MulDivStart}, 32'd0);
        chk("rst_busy", {31'd0, bus.MulDivBusy}, 32'd0);
        chk("rst_stallcnt", {16'd0, bus.StallCycles}, 32'd0);
        rst_n = 1'b1;

        // Load-use on rs
        bus.IDEXMemRead = 1'b1; bus.IDEXRd = 5'd8; bus.IFIDRs = 5'd8;
        #1;
        chk_ctl("lu_stall", 1'b1);
        chk("lu_cnt_before", {16'd0, bus.StallCycles}, 32'd0);
        tick();
        clear_inputs();
        #1;
        chk_ctl("lu_release", 1'b0);
        chk("lu_cnt_after", {16'd0, bus.StallCycles}, 32'd1);

        // Load into $0 never stalls
        bus.IDEXMemRead = 1'b1; bus.IDEXRd = 5'd0; bus.IFIDRs = 5'd0;
        #1;
        chk_ctl("lu_r0", 1'b0);
        tick();
        clear_inputs();
        #1;
        chk("lu_r0_cnt", {16'd0, bus.StallCycles}, 32'd1);

        // rt match ignored when the instruction does not read rt
        bus.IDBranch = 1'b1; bus.IDEXRegWrite = 1'b1; bus.IDEXRd = 5'd9; bus.IFIDRt = 5'd9;
        bus.IFIDUsesRt = 1'b0; bus.IFIDRs = 5'd3;
        #1;
        chk_ctl("br_rt_unused", 1'b0);
        clear_inputs();
        #1;

        // Branch after ALU writer: stall, and a taken result is suppressed
        bus.IDBranch = 1'b1; bus.IDEXRegWrite = 1'b1; bus.IDEXRd = 5'd9; bus.IFIDRt = 5'd9;
        bus.IFIDUsesRt = 1'b1; bus.BranchTaken = 1'b1;
        #1;
        chk_ctl("br_ex_stall", 1'b1);
        chk("br_ex_noflush", {31'd0, bus.IFIDFlush}, 32'd0);
        tick();

        // Writer now in MEM as a load
        bus.IDEXRegWrite = 1'b0; bus.IDEXRd = 5'd0; bus.BranchTaken = 1'b0;
        bus.EXMEMMemRead = 1'b1; bus.EXMEMRd = 5'd9;
        #1;
        chk_ctl("br_mem_stall", 1'b1);
        chk("br_mem_noflush", {31'd0, bus.IFIDFlush}, 32'd0);
        tick();

        // Operands ready, branch taken
        bus.EXMEMMemRead = 1'b0; bus.EXMEMRd = 5'd0; bus.BranchTaken = 1'b1;
        #1;
        chk_ctl("br_go", 1'b0);
        chk("br_flush", {31'd0, bus.IFIDFlush}, 32'd1);
        chk("br_cnt", {16'd0, bus.StallCycles}, 32'd3);
        tick();
        clear_inputs();
        #1;
        chk("br_flush_off", {31'd0, bus.IFIDFlush}, 32'd0);

        // MULT issue, then MFLO held in ID
        bus.IDMulDiv = 1'b1; bus.IDIsDiv = 1'b0;
        #1;
        chk("mult_start", {31'd0, bus.MulDivStart}, 32'd1);
        chk("mult_busy_pre", {31'd0, bus.MulDivBusy}, 32'd0);
        chk_ctl("mult_nostall", 1'b0);
        tick();
        bus.IDMulDiv = 1'b0; bus.IDReadsHiLo = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("mult_busy", {31'd0, bus.MulDivBusy}, 32'd1);
            chk_ctl("mflo_stall", 1'b1);
            chk("mult_start_off", {31'd0, bus.MulDivStart}, 32'd0);
            tick();
        end
        #1;
        chk("mult_done", {31'd0, bus.MulDivBusy}, 32'd0);
        chk_ctl("mflo_go", 1'b0);
        chk("mult_cnt", {16'd0, bus.StallCycles}, 32'd7);
        tick();
        clear_inputs();

        // Back-to-back DIV from a clean counter
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.IDMulDiv = 1'b1; bus.IDIsDiv = 1'b1;
        #1;
        chk("div1_start", {31'd0, bus.MulDivStart}, 32'd1);
        tick();
        for (int k = 0; k < 32; k++) begin
            #1;
            chk("div_busy", {31'd0, bus.MulDivBusy}, 32'd1);
            chk_ctl("div2_stall", 1'b1);
            chk("div2_start_off", {31'd0, bus.MulDivStart}, 32'd0);
            tick();
        end
        #1;
        chk("div1_done", {31'd0, bus.MulDivBusy}, 32'd0);
        chk("div2_start", {31'd0, bus.MulDivStart}, 32'd1);
        chk("div_cnt", {16'd0, bus.StallCycles}, 32'd32);
        tick();
        clear_inputs();

        // Reset at Cnt=17 of the second DIV (Cnt=32 now)
        for (int k = 0; k < 15; k++) begin
            tick();
        end
        chk("div2_busy_mid", {31'd0, bus.MulDivBusy}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_mid_busy", {31'd0, bus.MulDivBusy}, 32'd0);
        chk("rst_mid_cnt", {16'd0, bus.StallCycles}, 32'd0);
        bus.IDReadsHiLo = 1'b1;
        #1;
        chk_ctl("mfhi_after_rst", 1'b0);
        tick();
        clear_inputs();
        #1;
        chk("mfhi_cnt", {16'd0, bus.StallCycles}, 32'd0);

        // Saturation: 20 load-use cycles on both instances
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.IDEXMemRead = 1'b1; bus.IDEXRd = 5'd12; bus.IFIDRt = 5'd12; bus.IFIDUsesRt = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
        end
        clear_inputs();
        #1;
        chk("sat_wide_cnt", {16'd0, bus.StallCycles}, 32'd20);
        chk("sat_narrow_cnt", {28'd0, sat_bus.StallCycles}, 32'd15);
        tick();
        chk("sat_narrow_hold", {28'd0, sat_bus.StallCycles}, 32'd15);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
